mac_seq: RTL and testbench
==========================

# mac_seq

Multi-cycle multiply-accumulate sequencer built around the shared 8-bit `alu`. It accepts a stream of `len` operand pairs and, for each pair, issues one `ALU_MULT` (Q1.7 fractional product) and one `ALU_ADD` into an accumulator. It presents the final dot product on a valid/ready output. The block sits between the instruction/control path and the datapath ALU, so dot products and affine-transform rows run without per-step decoding.

## Interface
- `n`, 8, data width; only 8 is supported because the `ALU_MULT` slice is fixed at bits [14:7].
- `MAX_LEN`, 8, maximum number of operand pairs per job.
- `LW`, `$clog2(MAX_LEN+1)`, width of `len`.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: job request; sampled only in IDLE.
- `len` in LW: number of pairs, sampled with `start`; values above `MAX_LEN` clamp to `MAX_LEN`.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: sequencer can take a pair.
- `in_a`, `in_b` in n: signed Q1.7 operands.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_q` out n: signed Q1.7 accumulated result.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, FETCH, MULT, ACC, DONE.
- **IDLE**
  - `start`=1: `acc`←0, `remaining`←clamped `len`.
  - Next state is FETCH if `len`≠0, else DONE.
- **FETCH**
  - `in_ready`=1.
  - On `in_valid&&in_ready`: latch `opA`/`opB`, go to MULT; otherwise stay.
- **MULT**
  - ALU (`a`=`opA`, `b`=`opB`, `ALU_MULT`); `prod`←q.
  - Always goes to ACC.
- **ACC**
  - ALU (`a`=`acc`, `b`=`prod`, `ALU_ADD`); `acc`←result (see Configuration).
  - `remaining`−1; go to DONE if it reaches 0, else FETCH.
- **DONE**
  - `out_valid`=1, `out_q`=`acc`, held stable until `out_ready`=1.
  - Then go to IDLE.
- One `alu` instance is shared through the input muxes. In IDLE, FETCH and DONE the ALU is driven with `ALU_A`; its output is ignored.
- `start` while `busy` is ignored; it is not queued.
- Arithmetic:
  - Product is the signed 16-bit a*b, bits [14:7], i.e. truncated toward −∞.
  - Sum wraps modulo 2^8 unless saturation is enabled.
- `in_ready` and `out_valid` are registered state decodes with no combinational path from inputs.

## Timing
- Reset values (next edge with `reset`=1, from any state):
  - state IDLE.
  - `acc`, `prod`, `opA`, `opB`, `remaining`, `out_q` all 0.
  - `in_ready`=0, `out_valid`=0, `busy`=0.
- Latency: with `start` at cycle T and `in_valid` held high, `out_valid` rises at T+1+3·`len`. `len`=0 gives T+1 with `out_q`=0.
- Each cycle FETCH waits for `in_valid` adds exactly one cycle.
- Each cycle DONE waits for `out_ready` adds one cycle. The earliest new `start` is sampled the cycle after the output handshake.
- Reset mid-job (any state) aborts the job: the partial `acc` is discarded and no `out_valid` is produced.

## Configuration
- `MAC_SEQ_SATURATE_EN` defined:
  - In ACC, if `acc` and `prod` have equal signs and the ALU sum's sign differs, `acc` clamps.
  - Clamp values: 0x7F for positive overflow, 0x80 for negative overflow.
  - Saturation sticks only through the arithmetic itself; later terms may pull `acc` back into range.
- Undefined: `acc` takes the ALU sum directly (two's-complement wrap). Overflow detection logic is absent.

## Structure
- Package `opcodes`:
  - Reuse `alu_functions_t`.
  - Add `mac_state_t` (enum IDLE, FETCH, MULT, ACC, DONE).
  - Add constants `Q_MAX`=8'h7F and `Q_MIN`=8'h80.
- Sub-module: `alu` (existing), instantiated once with `n`=8. There is no other sub-module; the FSM and registers are local.

## Test plan
- `len`=2, pairs (0x40,0x40)×2, `in_valid`/`out_ready` always 1 → `out_q`=0x40, `out_valid` at T+7, held 1 cycle, `busy` low at T+8.
- `len`=1, (0x80,0x40) → product 0xC0; `out_q`=0xC0 at T+4.
- `len`=2, (0x7F,0x7F)×2 (126+126) → `out_q`=0xFC without the macro, 0x7F with `MAC_SEQ_SATURATE_EN`.
- Backpressure:
  - `len`=1, `in_valid` low 5 cycles after FETCH entry → `out_valid` at T+9.
  - Hold `out_ready` low 3 cycles → `out_q` stable, `out_valid` high 4 cycles; `start` pulsed meanwhile is ignored.
- `len`=0 → `out_valid` at T+1, `out_q`=0x00, `in_ready` never high.
- Reset asserted in MULT of a `len`=3 job → next cycle `busy`=0, `out_valid`=0. New job `len`=1 (0x40,0x40) → `out_q`=0x20, confirming `acc` was cleared.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared opcodes and types for mac_seq and the 8-bit alu.
package opcodes;

    localparam int unsigned N       = 8;
    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LW      = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        ALU_A,
        ALU_B,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_MULT
    } alu_functions_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MULT,
        ACC,
        DONE
    } mac_state_t;

    localparam logic [N-1:0] Q_MAX = 8'h7F;
    localparam logic [N-1:0] Q_MIN = 8'h80;

    // Job lengths above MAX_LEN run as MAX_LEN pairs.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        return (l > LW'(MAX_LEN)) ? LW'(MAX_LEN) : l;
    endfunction

endpackage

// File: rtl/mac_seq_if.sv
// Job, operand-stream and result handshake bundle for mac_seq.
interface mac_seq_if;
    import opcodes::*;

    logic          start;
    logic [LW-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic [N-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_q;
    logic          busy;

    modport master (
        output start, len, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_q, busy
    );

    modport slave (
        input  start, len, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_q, busy
    );

endinterface

// File: rtl/alu.sv
// Combinational n-bit ALU; ALU_MULT returns the Q1.7 product slice [2n-2:n-1].
module alu
    import opcodes::*;
#(
    parameter int unsigned n = 8
) (
    input  logic [n-1:0]   a_i,
    input  logic [n-1:0]   b_i,
    input  alu_functions_t func_i,
    output logic [n-1:0]   q_c_o
);

    localparam int unsigned PW = 2 * n;

    logic signed [PW-1:0] prod_c;

    assign prod_c = PW'($signed(a_i)) * PW'($signed(b_i));

    always_comb begin
        q_c_o = a_i;
        case (func_i)
            ALU_A:    q_c_o = a_i;
            ALU_B:    q_c_o = b_i;
            ALU_ADD:  q_c_o = a_i + b_i;
            ALU_SUB:  q_c_o = a_i - b_i;
            ALU_AND:  q_c_o = a_i & b_i;
            ALU_OR:   q_c_o = a_i | b_i;
            ALU_XOR:  q_c_o = a_i ^ b_i;
            ALU_MULT: q_c_o = n'(prod_c >>> (n - 1));
            default:  q_c_o = a_i;
        endcase
    end

endmodule

// File: rtl/mac_seq.sv
// Multiply-accumulate sequencer sharing one alu; define MAC_SEQ_SATURATE_EN for clamped accumulation.
module mac_seq
    import opcodes::*;
(
    input  logic      clk,
    input  logic      reset,
    mac_seq_if.slave  bus
);

    mac_state_t     state_q, state_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   prod_q, prod_d;
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_b_q, op_b_d;
    logic [LW-1:0]  remaining_q, remaining_d;
    logic [N-1:0]   out_q_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           busy_q;

    logic [N-1:0]   alu_a, alu_b, alu_res_c;
    alu_functions_t alu_func;

    alu #(.n(N)) u_alu (
        .a_i    (alu_a),
        .b_i    (alu_b),
        .func_i (alu_func),
        .q_c_o  (alu_res_c)
    );

    // Next-state, datapath updates and shared ALU operand muxing.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        remaining_d = remaining_q;
        alu_a       = op_a_q;
        alu_b       = op_b_q;
        alu_func    = ALU_A;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d       = '0;
                    remaining_d = clamp_len(bus.len);
                    state_d     = (bus.len != '0) ? FETCH : DONE;
                end
            end
            FETCH: begin
                if (bus.in_valid && in_ready_q) begin
                    op_a_d  = bus.in_a;
                    op_b_d  = bus.in_b;
                    state_d = MULT;
                end
            end
            MULT: begin
                alu_func = ALU_MULT;
                prod_d   = alu_res_c;
                state_d  = ACC;
            end
            ACC: begin
                alu_a    = acc_q;
                alu_b    = prod_q;
                alu_func = ALU_ADD;
`ifdef MAC_SEQ_SATURATE_EN
                if ((acc_q[N-1] == prod_q[N-1]) && (alu_res_c[N-1] != acc_q[N-1])) begin
                    acc_d = acc_q[N-1] ? Q_MIN : Q_MAX;
                end else begin
                    acc_d = alu_res_c;
                end
`else
                acc_d = alu_res_c;
`endif
                remaining_d = remaining_q - LW'(1);
                state_d     = (remaining_d == '0) ? DONE : FETCH;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they align with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            prod_q      <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            remaining_q <= '0;
            out_q_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            remaining_q <= remaining_d;
            if (state_d == DONE) begin
                out_q_q <= acc_d;
            end
            in_ready_q  <= (state_d == FETCH);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_q     = out_q_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: latency, arithmetic, clamping, backpressure and reset abort.
module tb_mac_seq;
    import opcodes::*;

    logic clk = 1'b0;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;

    mac_seq_if bus ();

    mac_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef MAC_SEQ_SATURATE_EN
    localparam logic [7:0] EXP_POS = 8'h7F;
    localparam logic [7:0] EXP_NEG = 8'h80;
`else
    localparam logic [7:0] EXP_POS = 8'hFC;
    localparam logic [7:0] EXP_NEG = 8'h02;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_pair(input logic [7:0] a, input logic [7:0] b);
        bus.in_a = a;
        bus.in_b = b;
    endtask

    // Cycle T is the cycle start is held high; returns in cycle T+1.
    task automatic start_job(input logic [LW-1:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        cyc       = 0;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_cyc, input logic [7:0] exp_q);
        while (!bus.out_valid && cyc < 100) tick();
        check({tag, " latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " out_q"}, 32'(bus.out_q), 32'(exp_q));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        repeat (3) tick();
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_q", 32'(bus.out_q), 32'd0);
        reset = 1'b0;
        tick();

        // 0.5*0.5 twice -> 0.5
        set_pair(8'h40, 8'h40);
        bus.in_valid = 1'b1;
        start_job(4'd2);
        check("t1 busy", 32'(bus.busy), 32'd1);
        check("t1 in_ready", 32'(bus.in_ready), 32'd1);
        wait_valid("t1", 7, 8'h40);
        tick();
        check("t1 out_valid drop", 32'(bus.out_valid), 32'd0);
        check("t1 busy drop", 32'(bus.busy), 32'd0);

        set_pair(8'h80, 8'h40);
        start_job(4'd1);
        wait_valid("t2", 4, 8'hC0);
        tick();

        set_pair(8'h7F, 8'h7F);
        start_job(4'd2);
        wait_valid("t3 pos ovf", 7, EXP_POS);
        tick();

        set_pair(8'h80, 8'h7F);
        start_job(4'd2);
        wait_valid("t3 neg ovf", 7, EXP_NEG);
        tick();

        // len 15 clamps to 8 pairs of 0x08
        set_pair(8'h20, 8'h20);
        start_job(4'hF);
        wait_valid("len clamp", 25, 8'h40);
        tick();

        set_pair(8'h40, 8'h40);
        bus.in_valid = 1'b0;
        start_job(4'd1);
        repeat (5) tick();
        check("inbp in_ready", 32'(bus.in_ready), 32'd1);
        check("inbp busy", 32'(bus.busy), 32'd1);
        bus.in_valid = 1'b1;
        wait_valid("inbp", 9, 8'h20);
        tick();

        set_pair(8'h80, 8'h40);
        bus.out_ready = 1'b0;
        start_job(4'd1);
        wait_valid("outbp", 4, 8'hC0);
        bus.start = 1'b1;
        bus.len   = 4'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("outbp hold valid", 32'(bus.out_valid), 32'd1);
            check("outbp hold q", 32'(bus.out_q), 32'hC0);
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("outbp release", 32'(bus.out_valid), 32'd0);
        tick();
        check("outbp start ignored", 32'(bus.busy), 32'd0);

        set_pair(8'h7F, 8'h7F);
        start_job(4'd3);
        tick();
        check("abort in mult busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort in_ready", 32'(bus.in_ready), 32'd0);
        check("abort out_q", 32'(bus.out_q), 32'd0);
        seen = 0;
        repeat (12) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("abort no result", 32'(seen), 32'd0);
        set_pair(8'h40, 8'h40);
        start_job(4'd1);
        wait_valid("after abort", 4, 8'h20);
        tick();

        start_job(4'd0);
        check("len0 in_ready", 32'(bus.in_ready), 32'd0);
        wait_valid("len0", 1, 8'h00);
        tick();
        check("len0 in_ready after", 32'(bus.in_ready), 32'd0);
        check("len0 done", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
